rcn_master_arb: RTL
===================

// Module: rcn_master_arb
// PURPOSE
//  Two-port rcn bus master. Round-robin arbitrates between two local requesters (e.g. CPU, DMA)
//  and inserts their requests into free ring slots. Tracks up to 4 outstanding transactions by
//  seq tag and routes each response back to its owner. Sits in the ring like any rcn node:
//  one register stage in, one out.
// PARAMETERS
//  MASTER_ID       6'd0   value driven into src_id [65:60]; responses are matched on it
//  TIMEOUT_CYCLES  1024   cycles before an outstanding entry expires (RCN_MASTER_ARB_TIMEOUT_EN only)
// PORTS
//  clk         in   1   clock
//  rst         in   1   synchronous, active-high reset
//  rcn_in      in   69  ring input
//  rcn_out     out  69  ring output (registered)
//  req_valid   in   2   per-requester request valid, bit n = requester n
//  req_ready   out  2   request accepted this cycle (combinational)
//  req_wr      in   2   1 = write
//  req_mask    in   8   byte mask, {req1[3:0], req0[3:0]}
//  req_addr    in   48  byte address, {req1[23:0], req0[23:0]}; bits [1:0] ignored
//  req_wdata   in   64  write data, {req1, req0}
//  resp_valid  out  2   one-cycle response strobe to requester n (registered)
//  resp_wr     out  1   write flag echoed from response
//  resp_rdata  out  32  read data, valid with resp_valid
//  resp_err    out  1   1 = entry expired (timeout); 0 when timeout is compiled out
// BEHAVIOUR
//  - Packet: [68] valid, [67] 1=req/0=resp, [66] wr, [65:60] src_id, [59:56] mask,
//    [55:34] addr[23:2], [33:32] seq, [31:0] data.
//  - rin <= rcn_in every cycle. A slot is free when !rin[68], or when rin is a response for us:
//    rin[68] && !rin[67] && rin[65:60]==MASTER_ID.
//  - Response for us: slot consumed (not forwarded). If entry rin[33:32] is busy: next cycle
//    resp_valid[owner]=1, resp_wr=rin[66], resp_rdata=rin[31:0], entry cleared. If not busy:
//    dropped silently, no strobe.
//  - Seq table: 4 entries {busy, owner}. Allocation takes the lowest-index entry whose
//    *registered* busy=0. An entry freed this cycle cannot be reallocated until the next cycle.
//  - Grant: round-robin pointer selects requester; if only one is valid it wins. Pointer moves
//    past the winner only when a request is accepted.
//  - req_ready[n] = grant[n] & slot_free & table_not_full; at most one bit set.
//  - Accept: rout <= {1,1,req_wr[n],MASTER_ID,req_mask[n],req_addr[n][23:2],seq,req_wdata[n]}.
//    Freed response slot + insertion in the same cycle is legal.
//  - Otherwise: rout <= consumed ? 69'd0 : rin. Ring latency through the block is 2 cycles.
//  - Reset: rin, rout = 0; resp_valid = 0; resp_wr = 0; resp_rdata = 0; resp_err = 0;
//    all entries not busy; pointer = 0. Reset mid-transaction drops every outstanding entry.
//    Late responses for dropped entries are consumed and discarded.
//  - Table full or slot occupied: req_ready = 0. Requester holds valid and payload stable.
// CONFIGURATION
//  - RCN_MASTER_ARB_TIMEOUT_EN defined: each busy entry has a cycle counter, cleared on
//    allocation. At TIMEOUT_CYCLES-1 the entry is freed and resp_valid[owner]=1 with
//    resp_err=1 and resp_rdata=32'hDEAD_DEAD.
//    A response and an expiry for the same entry in the same cycle: the response wins,
//    resp_err=0.
//  - RCN_MASTER_ARB_TIMEOUT_EN not defined: no counters; entries wait indefinitely;
//    resp_err tied to 0.
// STRUCTURE
//  - rcn_pkg: packet field bit positions, RCN_PKT_W=69, SEQ_W=2, NUM_SEQ=4.
//  - Sub-module rcn_seq_table: alloc/free/owner lookup, plus the optional timeout counters.
//  - Arbiter, insertion mux and ring registers live in this module.
// TESTING
//  - Idle ring, req0 read addr 0x000104 -> cycle+1 rcn_out valid req, seq 0, addr field 0x41.
//    Loop back as a response with data 0x12345678 -> resp_valid=2'b01, resp_rdata=0x12345678.
//  - Both requesters valid for 4 accepts -> grants alternate 0,1,0,1; seqs 0,1,2,3.
//    A 5th request stalls (req_ready=0) until one response returns.
//  - Ring fully occupied by foreign packets (MASTER_ID+1) -> no insertion; packets pass
//    unchanged with 2-cycle latency.
//  - Response for seq 2 while a request is pending -> same slot reused; the new request gets
//    seq 0 or 1, never seq 2 that cycle.
//  - Response with a non-busy seq -> consumed, no resp_valid.
//    Assert rst mid-flight -> outputs zeroed, table empty.
//  - TIMEOUT_EN, TIMEOUT_CYCLES=16, response never returns -> after 16 cycles resp_err=1,
//    rdata=0xDEADDEAD, entry reusable.

Source files
------------

// File: rtl/rcn_pkg.sv
// Shared rcn ring definitions: packet field positions, widths and a request packer.
package rcn_pkg;

  localparam int unsigned RCN_PKT_W = 69;
  localparam int unsigned SEQ_W     = 2;
  localparam int unsigned NUM_SEQ   = 4;

  localparam int unsigned PktValid  = 68;
  localparam int unsigned PktReq    = 67;
  localparam int unsigned PktWr     = 66;
  localparam int unsigned PktSrcHi  = 65;
  localparam int unsigned PktSrcLo  = 60;
  localparam int unsigned PktMaskHi = 59;
  localparam int unsigned PktMaskLo = 56;
  localparam int unsigned PktAddrHi = 55;
  localparam int unsigned PktAddrLo = 34;
  localparam int unsigned PktSeqHi  = 33;
  localparam int unsigned PktSeqLo  = 32;
  localparam int unsigned PktDataHi = 31;

  typedef logic [RCN_PKT_W-1:0] rcn_pkt_t;

  function automatic rcn_pkt_t rcn_pack_req(input logic wr, input logic [5:0] src,
                                            input logic [3:0] mask, input logic [21:0] addr_w,
                                            input logic [SEQ_W-1:0] seq,
                                            input logic [31:0] data);
    return {1'b1, 1'b1, wr, src, mask, addr_w, seq, data};
  endfunction

endpackage

// File: rtl/rcn_seq_table.sv
// Outstanding-transaction table: seq allocation, response owner lookup and, with
// RCN_MASTER_ARB_TIMEOUT_EN defined, per-entry expiry counters.
module rcn_seq_table
  import rcn_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             alloc_i,
  input  logic             alloc_owner_i,
  input  logic             rsp_i,
  input  logic [SEQ_W-1:0] rsp_seq_i,
  output logic             full_o,
  output logic [SEQ_W-1:0] alloc_seq_o,
  output logic             hit_o,
  output logic             hit_owner_o,
  output logic             exp_o,
  output logic             exp_owner_o
);

  logic [NUM_SEQ-1:0] busy_q, busy_d;
  logic [NUM_SEQ-1:0] owner_q, owner_d;
  logic [SEQ_W-1:0]   exp_seq;

  assign full_o      = &busy_q;
  assign hit_o       = rsp_i & busy_q[rsp_seq_i];
  assign hit_owner_o = owner_q[rsp_seq_i];

  // Lowest-index free entry, from registered state only.
  always_comb begin
    alloc_seq_o = '0;
    for (int i = NUM_SEQ - 1; i >= 0; i--) begin
      if (!busy_q[i]) alloc_seq_o = SEQ_W'(i);
    end
  end

`ifdef RCN_MASTER_ARB_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] cnt_q [NUM_SEQ];
  logic [CntW-1:0] cnt_d [NUM_SEQ];

  // A response owns the single strobe this cycle; a pending expiry waits at CntMax.
  always_comb begin
    exp_o   = 1'b0;
    exp_seq = '0;
    for (int i = NUM_SEQ - 1; i >= 0; i--) begin
      if (busy_q[i] && (cnt_q[i] == CntMax) && !hit_o) begin
        exp_o   = 1'b1;
        exp_seq = SEQ_W'(i);
      end
    end
    exp_owner_o = owner_q[exp_seq];
  end

  always_comb begin
    for (int i = 0; i < NUM_SEQ; i++) begin
      cnt_d[i] = cnt_q[i];
      if (busy_q[i] && (cnt_q[i] != CntMax)) cnt_d[i] = cnt_q[i] + 1'b1;
      if (alloc_i && (alloc_seq_o == SEQ_W'(i))) cnt_d[i] = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NUM_SEQ; i++) begin
      if (rst_i) cnt_q[i] <= '0;
      else       cnt_q[i] <= cnt_d[i];
    end
  end
`else
  assign exp_o       = 1'b0;
  assign exp_seq     = '0;
  assign exp_owner_o = 1'b0;
`endif

  always_comb begin
    busy_d  = busy_q;
    owner_d = owner_q;
    if (hit_o) busy_d[rsp_seq_i] = 1'b0;
    if (exp_o) busy_d[exp_seq]   = 1'b0;
    if (alloc_i) begin
      busy_d[alloc_seq_o]  = 1'b1;
      owner_d[alloc_seq_o] = alloc_owner_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q  <= '0;
      owner_q <= '0;
    end else begin
      busy_q  <= busy_d;
      owner_q <= owner_d;
    end
  end

endmodule

// File: rtl/rcn_master_arb.sv
// Two-port rcn ring master: round-robin arbiter, slot insertion and response routing.
// Optional entry timeout is enabled by defining RCN_MASTER_ARB_TIMEOUT_EN.
module rcn_master_arb
  import rcn_pkg::*;
#(
  parameter logic [5:0]  MASTER_ID      = 6'd0,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [RCN_PKT_W-1:0] rcn_in_i,
  output logic [RCN_PKT_W-1:0] rcn_out_o,
  input  logic [1:0]           req_valid_i,
  output logic [1:0]           req_ready_o,
  input  logic [1:0]           req_wr_i,
  input  logic [7:0]           req_mask_i,
  input  logic [47:0]          req_addr_i,
  input  logic [63:0]          req_wdata_i,
  output logic [1:0]           resp_valid_o,
  output logic                 resp_wr_o,
  output logic [31:0]          resp_rdata_o,
  output logic                 resp_err_o
);

  rcn_pkt_t         rin_q, rout_q, rout_d;
  logic             ptr_q, ptr_d;
  logic [1:0]       grant;
  logic             resp_for_us, slot_free, full, accept, win;
  logic [SEQ_W-1:0] alloc_seq;
  logic             hit, hit_owner, exp_v, exp_owner;
  logic [1:0]       resp_valid_q, resp_valid_d;
  logic             resp_wr_q, resp_wr_d, resp_err_q, resp_err_d;
  logic [31:0]      resp_rdata_q, resp_rdata_d;
  logic             unused_addr_lsbs;

  assign unused_addr_lsbs = ^{req_addr_i[25:24], req_addr_i[1:0]};

  assign resp_for_us = rin_q[PktValid] & ~rin_q[PktReq] &
                       (rin_q[PktSrcHi:PktSrcLo] == MASTER_ID);
  assign slot_free   = ~rin_q[PktValid] | resp_for_us;

  always_comb begin
    case (req_valid_i)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = ptr_q ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

  assign req_ready_o = grant & {2{slot_free & ~full}};
  assign accept      = |req_ready_o;
  assign win         = req_ready_o[1];
  assign ptr_d       = accept ? ~win : ptr_q;

  rcn_seq_table #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_seq_table (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .alloc_i       (accept),
    .alloc_owner_i (win),
    .rsp_i         (resp_for_us),
    .rsp_seq_i     (rin_q[PktSeqHi:PktSeqLo]),
    .full_o        (full),
    .alloc_seq_o   (alloc_seq),
    .hit_o         (hit),
    .hit_owner_o   (hit_owner),
    .exp_o         (exp_v),
    .exp_owner_o   (exp_owner)
  );

  // A consumed response slot may carry a new request in the same cycle.
  always_comb begin
    if (accept) begin
      rout_d = rcn_pack_req(win ? req_wr_i[1] : req_wr_i[0], MASTER_ID,
                            win ? req_mask_i[7:4] : req_mask_i[3:0],
                            win ? req_addr_i[47:26] : req_addr_i[23:2], alloc_seq,
                            win ? req_wdata_i[63:32] : req_wdata_i[31:0]);
    end else if (resp_for_us) begin
      rout_d = '0;
    end else begin
      rout_d = rin_q;
    end
  end

  always_comb begin
    resp_valid_d = 2'b00;
    resp_wr_d    = resp_wr_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    if (hit) begin
      resp_valid_d = hit_owner ? 2'b10 : 2'b01;
      resp_wr_d    = rin_q[PktWr];
      resp_rdata_d = rin_q[PktDataHi:0];
      resp_err_d   = 1'b0;
    end else if (exp_v) begin
      resp_valid_d = exp_owner ? 2'b10 : 2'b01;
      resp_wr_d    = 1'b0;
      resp_rdata_d = 32'hDEAD_DEAD;
      resp_err_d   = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rin_q        <= '0;
      rout_q       <= '0;
      ptr_q        <= 1'b0;
      resp_valid_q <= 2'b00;
      resp_wr_q    <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      rin_q        <= rcn_in_i;
      rout_q       <= rout_d;
      ptr_q        <= ptr_d;
      resp_valid_q <= resp_valid_d;
      resp_wr_q    <= resp_wr_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign rcn_out_o    = rout_q;
  assign resp_valid_o = resp_valid_q;
  assign resp_wr_o    = resp_wr_q;
  assign resp_rdata_o = resp_rdata_q;
  assign resp_err_o   = resp_err_q;

endmodule
